alu_7seg_scan: RTL and testbench

- Parametrised successor to the 4-bit ALU / single-digit 7-segment decoder.
- Registered WIDTH-bit ALU (add, sub, or, xor) with carry/borrow and zero flags, plus start/done handshake.
- Drives a time-multiplexed multi-digit hex display: one shared segment bus, one-hot active-low digit enables, prescaled scan counter.
- Sits between operand/switch logic and the board's multi-digit display.

---
 rtl/alu_7seg_scan.sv | 113 +++++++++++
 tb/tb_alu_7seg_scan.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_7seg_scan.sv
// Registered WIDTH-bit ALU (add/sub/or/xor) with carry and zero flags, driving a
// time-multiplexed hex display of the result through a prescaled digit scanner.
module alu_7seg_scan #(
   parameter int WIDTH    = 8,
   parameter int SCAN_DIV = 1000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [1:0]         opcode,
   input  logic               start,
   input  logic               en,
   output logic [WIDTH-1:0]   result,
   output logic               carry,
   output logic               zero,
   output logic               done,
   output logic [6:0]         seg,
   output logic [WIDTH/4-1:0] an
);
   localparam int NDIG = WIDTH / 4;
   localparam int PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   logic [WIDTH:0]  alu_p0;
   logic            alu_c_p0;
   logic [PW-1:0]   pcnt;
   logic [IW-1:0]   idx;
   logic [3:0]      nib;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b0111111;
         4'h1: hex7 = 7'b0000110;
         4'h2: hex7 = 7'b1011011;
         4'h3: hex7 = 7'b1001111;
         4'h4: hex7 = 7'b1100110;
         4'h5: hex7 = 7'b1101101;
         4'h6: hex7 = 7'b1111101;
         4'h7: hex7 = 7'b0000111;
         4'h8: hex7 = 7'b1111111;
         4'h9: hex7 = 7'b1101111;
         4'hA: hex7 = 7'b1110111;
         4'hB: hex7 = 7'b1111100;
         4'hC: hex7 = 7'b0111001;
         4'hD: hex7 = 7'b1011110;
         4'hE: hex7 = 7'b1111001;
         default: hex7 = 7'b1110001;
      endcase
   endfunction

   // Stage p0: combinational ALU; the extra MSB carries carry-out or borrow
   always_comb begin
      alu_p0   = '0;
      alu_c_p0 = 1'b0;
      case (opcode)
         2'b00: begin
            alu_p0   = {1'b0, A} + {1'b0, B};
            alu_c_p0 = alu_p0[WIDTH];
         end
         2'b10: begin
            alu_p0   = {1'b0, A} - {1'b0, B};
            alu_c_p0 = alu_p0[WIDTH];
         end
         2'b01:   alu_p0 = {1'b0, A | B};
         default: alu_p0 = {1'b0, A ^ B};
      endcase
   end

   always_comb begin
      nib = 4'h0;
      for (int i = 0; i < NDIG; i++) begin
         if (idx == IW'(i)) nib = result[4*i +: 4];
      end
   end

   // Stage p1: result/flag registers, scan counters and display registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result <= '0;
         carry  <= 1'b0;
         zero   <= 1'b1;
         done   <= 1'b0;
         pcnt   <= '0;
         idx    <= '0;
         seg    <= 7'b0;
         an     <= '1;
      end else begin
         done <= start;
         if (start) begin
            result <= alu_p0[WIDTH-1:0];
            carry  <= alu_c_p0;
            zero   <= (alu_p0[WIDTH-1:0] == '0);
         end

         if (pcnt == PW'(SCAN_DIV - 1)) begin
            pcnt <= '0;
            idx  <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
         end else begin
            pcnt <= pcnt + PW'(1);
         end

         // Blanking only gates the drivers; the scan position keeps running
         if (en) begin
            an  <= ~(NDIG'(1) << idx);
            seg <= hex7(nib);
         end else begin
            an  <= '1;
            seg <= 7'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_7seg_scan.sv
// Directed self-checking bench: an 8-bit/SCAN_DIV=4 instance for ALU and scan
// behaviour, and a 4-bit instance for the full hex pattern table.
module tb_alu_7seg_scan;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] a8, b8;
   logic [1:0] op8;
   logic       start8, en8;
   logic [7:0] result8;
   logic       carry8, zero8, done8;
   logic [6:0] seg8;
   logic [1:0] an8;

   logic [3:0] a4, b4;
   logic [1:0] op4;
   logic       start4, en4;
   logic [3:0] result4;
   logic       carry4, zero4, done4;
   logic [6:0] seg4;
   logic [0:0] an4;

   int errors = 0;
   int checks = 0;

   logic [6:0] pat [0:15] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                              7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                              7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                              7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

   always #5 clk = ~clk;

   alu_7seg_scan #(.WIDTH(8), .SCAN_DIV(4)) dut8 (
      .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .opcode(op8), .start(start8),
      .en(en8), .result(result8), .carry(carry8), .zero(zero8), .done(done8),
      .seg(seg8), .an(an8));

   alu_7seg_scan #(.WIDTH(4), .SCAN_DIV(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .opcode(op4), .start(start4),
      .en(en4), .result(result4), .carry(carry4), .zero(zero4), .done(done4),
      .seg(seg4), .an(an4));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en8 = 1'b1; start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; op8 = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({result8, zero8, carry8, done8, seg8, an8} !== {8'h00, 1'b1, 1'b0, 1'b0, 7'b0, 2'b11}) begin
            errors++;
            $display("FAIL reset_hold[%0d]: got r=%h z=%b c=%b d=%b seg=%b an=%b, want r=00 z=1 c=0 d=0 seg=0000000 an=11",
                     i, result8, zero8, carry8, done8, seg8, an8);
         end
      end
      rst_n = 1'b1; start8 = 1'b0;
      tick();
      checks++;
      if ({seg8, an8, result8, done8} !== {7'b0111111, 2'b10, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset_release: got seg=%b an=%b r=%h d=%b, want seg=0111111 an=10 r=00 d=0",
                  seg8, an8, result8, done8);
      end
   endtask

   task automatic alu_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input logic [7:0] er, input logic ec, input logic ez, input string name);
      a8 = a; b8 = b; op8 = op; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      checks++;
      if ({result8, carry8, zero8, done8} !== {er, ec, ez, 1'b1}) begin
         errors++;
         $display("FAIL %s: got r=%h c=%b z=%b d=%b, want r=%h c=%b z=%b d=1",
                  name, result8, carry8, zero8, done8, er, ec, ez);
      end
      a8 = 8'h00; b8 = 8'h00;
      tick();
      checks++;
      if ({result8, carry8, zero8, done8} !== {er, ec, ez, 1'b0}) begin
         errors++;
         $display("FAIL %s_hold: got r=%h c=%b z=%b d=%b, want r=%h c=%b z=%b d=0",
                  name, result8, carry8, zero8, done8, er, ec, ez);
      end
   endtask

   task automatic test_alu();
      alu_op(8'hF0, 8'h25, 2'b00, 8'h15, 1'b1, 1'b0, "add_carry");
      alu_op(8'h10, 8'h11, 2'b10, 8'hFF, 1'b1, 1'b0, "sub_borrow");
      alu_op(8'h3C, 8'h3C, 2'b10, 8'h00, 1'b0, 1'b1, "sub_zero");
      alu_op(8'hA5, 8'h0F, 2'b01, 8'hAF, 1'b0, 1'b0, "or");
      alu_op(8'hA5, 8'h0F, 2'b11, 8'hAA, 1'b0, 1'b0, "xor");
   endtask

   task automatic test_back_to_back();
      a8 = 8'h01; b8 = 8'h02; op8 = 2'b00; start8 = 1'b1;
      tick();
      checks++;
      if ({result8, done8} !== {8'h03, 1'b1}) begin
         errors++;
         $display("FAIL b2b_first: got r=%h d=%b, want r=03 d=1", result8, done8);
      end
      a8 = 8'hFF; b8 = 8'h0F; op8 = 2'b11;
      tick();
      start8 = 1'b0;
      checks++;
      if ({result8, done8, zero8} !== {8'hF0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL b2b_second: got r=%h d=%b z=%b, want r=f0 d=1 z=0", result8, done8, zero8);
      end
      tick();
      checks++;
      if (done8 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done_drop: got d=%b, want d=0", done8);
      end
   endtask

   // Restarts the scan from reset; k counts edges after release, digit = ((k-1)/4)%2
   task automatic test_scan();
      logic [1:0] ean;
      logic [6:0] eseg;
      int         d;
      rst_n = 1'b0; en8 = 1'b1;
      tick();
      rst_n = 1'b1; a8 = 8'h7E; b8 = 8'h00; op8 = 2'b00; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int k = 2; k <= 28; k++) begin
         en8 = (k >= 17 && k <= 19) ? 1'b0 : 1'b1;
         tick();
         d = ((k - 1) / 4) % 2;
         if (!en8) begin
            ean = 2'b11; eseg = 7'b0;
         end else if (d == 0) begin
            ean = 2'b10; eseg = 7'b1111001;
         end else begin
            ean = 2'b01; eseg = 7'b0000111;
         end
         checks++;
         if ({an8, seg8} !== {ean, eseg}) begin
            errors++;
            $display("FAIL scan[k=%0d]: got an=%b seg=%b, want an=%b seg=%b", k, an8, seg8, ean, eseg);
         end
      end
   endtask

   task automatic test_hex_table();
      en4 = 1'b1; b4 = 4'h0; op4 = 2'b00;
      for (int v = 0; v < 16; v++) begin
         a4 = 4'(v); start4 = 1'b1;
         tick();
         start4 = 1'b0;
         tick();
         checks++;
         if ({seg4, an4, result4} !== {pat[v], 1'b0, 4'(v)}) begin
            errors++;
            $display("FAIL hex_%0h: got seg=%b an=%b r=%h, want seg=%b an=0 r=%h",
                     v, seg4, an4, result4, pat[v], v);
         end
      end
      a4 = 4'hF; b4 = 4'h1; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      checks++;
      if ({result4, carry4, zero4, done4} !== {4'h0, 1'b1, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL add_wrap4: got r=%h c=%b z=%b d=%b, want r=0 c=1 z=1 d=1",
                  result4, carry4, zero4, done4);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      a8 = '0; b8 = '0; op8 = '0; start8 = 1'b0; en8 = 1'b1;
      a4 = '0; b4 = '0; op4 = '0; start4 = 1'b0; en4 = 1'b1;
      test_reset();
      test_alu();
      test_back_to_back();
      test_scan();
      test_hex_table();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
